// File: rtl/main_memory_wt_controller.sv
// main_memory_wt_controller
// Main-memory stage behind the write-through data cache. Write-throughs are absorbed
// by a small FIFO that drains into the array one word at a time. Read misses are
// refilled one block at a time. Queued writes always commit before a refill starts,
// so a refill always returns data that includes every earlier write.
module main_memory_wt_controller #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WB_DEPTH        = 4,
    parameter int MEM_LAT         = 4
) (
    input  logic                                            CLK,
    input  logic                                            RST,
    input  logic                                            wr_valid,
    input  logic [ADDR_WIDTH-1:0]                           wr_addr,
    input  logic [DATA_WIDTH-1:0]                           wr_data,
    output logic                                            wr_ready,
    input  logic                                            rd_req,
    input  logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK)-1:0]   rd_block_addr,
    output logic                                            rd_busy,
    output logic                                            refill_valid,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0]              refill_idx,
    output logic [DATA_WIDTH-1:0]                           refill_data,
    output logic                                            refill_done,
    output logic                                            wb_empty
);

    localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_W   = ADDR_WIDTH - OFF_W;
    localparam int PTR_W   = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W   = $clog2(WB_DEPTH) + 1;
    localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [OFF_W-1:0] IDX_LAST = OFF_W'(WORDS_PER_BLOCK - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WB_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WB_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    // Storage: the main array and the write-buffer entries are not reset
    logic [DATA_WIDTH-1:0] r_mem       [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] r_fifoAddr  [0:WB_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_fifoData  [0:WB_DEPTH-1];

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    state_t                r_state;
    logic [LAT_W-1:0]      r_lat;
    logic [OFF_W-1:0]      r_idx;
    logic                  r_pending;
    logic [BLK_W-1:0]      r_blk;

    logic                  r_refillValid;
    logic [OFF_W-1:0]      r_refillIdx;
    logic [DATA_WIDTH-1:0] r_refillData;
    logic                  r_refillDone;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_headAddr;
    logic [DATA_WIDTH-1:0] w_headData;
    logic [ADDR_WIDTH-1:0] w_readAddr;

    // wr_ready comes from the registered count, so a pop this cycle frees space only next cycle
    assign wr_ready   = (r_count != CNT_FULL);
    assign w_push     = wr_valid && wr_ready;
    assign w_pop      = (r_state == ST_WRITE) && (r_lat == LAT_LAST);
    assign w_headAddr = r_fifoAddr[r_head];
    assign w_headData = r_fifoData[r_head];
    assign w_readAddr = {r_blk, r_idx};

    assign rd_busy      = r_pending;
    assign refill_valid = r_refillValid;
    assign refill_idx   = r_refillIdx;
    assign refill_data  = r_refillData;
    assign refill_done  = r_refillDone;
    assign wb_empty     = (r_count == '0) && (r_state != ST_WRITE);

    // Capture an accepted write-through into the buffer slot at the tail
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifoAddr[r_tail] <= wr_addr;
            r_fifoData[r_tail] <= wr_data;
        end
    end

    // Commit the buffer head into the array on the final latency cycle of a write
    always_ff @(posedge CLK) begin
        if (w_pop) begin
            r_mem[w_headAddr] <= w_headData;
        end
    end

    // Buffer pointers and occupancy; reset discards everything still queued
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= (r_tail == PTR_LAST) ? '0 : r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= (r_head == PTR_LAST) ? '0 : r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer: drains writes ahead of a pending refill and registers the refill outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= ST_IDLE;
            r_lat         <= '0;
            r_idx         <= '0;
            r_pending     <= 1'b0;
            r_blk         <= '0;
            r_refillValid <= 1'b0;
            r_refillIdx   <= '0;
            r_refillData  <= '0;
            r_refillDone  <= 1'b0;
        end else begin
            r_refillValid <= 1'b0;
            r_refillDone  <= 1'b0;

            if (rd_req && !r_pending) begin
                r_pending <= 1'b1;
                r_blk     <= rd_block_addr;
            end

            case (r_state)
                ST_IDLE: begin
                    r_lat <= '0;
                    r_idx <= '0;
                    if (r_pending && (r_count == '0)) begin
                        r_state <= ST_READ;
                    end else if (r_count != '0) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_lat == LAT_LAST) begin
                        r_lat   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                ST_READ: begin
                    if (r_lat == LAT_LAST) begin
                        r_lat         <= '0;
                        r_refillValid <= 1'b1;
                        r_refillIdx   <= r_idx;
                        r_refillData  <= r_mem[w_readAddr];
                        if (r_idx == IDX_LAST) begin
                            r_idx        <= '0;
                            r_refillDone <= 1'b1;
                            r_pending    <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + OFF_W'(1);
                        end
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_wt_controller.sv
// tb_main_memory_wt_controller
// Directed scenarios plus a randomized write/read mix, checked against a reference
// model: an array of committed words plus a queue of accepted, uncommitted writes.
module tb_main_memory_wt_controller;

    localparam int MEM_LAT = 4;
    localparam int WPB     = 4;

    logic        CLK;
    logic        RST;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic [7:0]  rd_block_addr;
    logic        rd_busy;
    logic        refill_valid;
    logic [1:0]  refill_idx;
    logic [31:0] refill_data;
    logic        refill_done;
    logic        wb_empty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    logic [31:0] modelMem   [1024];
    bit          modelValid [1024];
    wr_t         wq [$];

    main_memory_wt_controller #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .WORDS_PER_BLOCK(WPB), .WB_DEPTH(4), .MEM_LAT(MEM_LAT)
    ) dut (
        .CLK(CLK), .RST(RST),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_block_addr(rd_block_addr), .rd_busy(rd_busy),
        .refill_valid(refill_valid), .refill_idx(refill_idx), .refill_data(refill_data),
        .refill_done(refill_done), .wb_empty(wb_empty)
    );

    // Free-running clock, 10 time units per period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard stop in case some wait escapes its bound
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Every accepted write that is still queued becomes committed model state
    task automatic flushQueue();
        wr_t w;
        while (wq.size() > 0) begin
            w = wq.pop_front();
            modelMem[w.a]   = w.d;
            modelValid[w.a] = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_wr_ready"},     wr_ready,     1);
        checkOutput({pfx, "_rd_busy"},      rd_busy,      0);
        checkOutput({pfx, "_refill_valid"}, refill_valid, 0);
        checkOutput({pfx, "_refill_idx"},   refill_idx,   0);
        checkOutput({pfx, "_refill_data"},  refill_data,  0);
        checkOutput({pfx, "_refill_done"},  refill_done,  0);
        checkOutput({pfx, "_wb_empty"},     wb_empty,     1);
    endtask

    // Present one write and hold it until the buffer accepts it; returns at the negedge after the push
    task automatic applyStimulus(input logic [9:0] addr, input logic [31:0] data);
        bit accepted;
        int n;
        wr_t w;
        accepted = 1'b0;
        n = 0;
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        while (!accepted && n < 100) begin
            accepted = wr_ready;
            @(negedge CLK);
            n++;
        end
        wr_valid = 1'b0;
        wr_addr  = 10'($urandom);
        wr_data  = $urandom;
        checkOutput("wr_accept", accepted, 1);
        if (accepted) begin
            w.a = addr;
            w.d = data;
            wq.push_back(w);
        end
    endtask

    task automatic waitEmpty();
        int n;
        n = 0;
        while (!wb_empty && n < 500) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("wb_empty_wait", wb_empty, 1);
        flushQueue();
    endtask

    // Issue a refill and check each returned word; timed=1 requires an idle, empty buffer
    task automatic doRead(input logic [7:0] blk, input bit timed, input bit drainFirst);
        int n;
        int got;
        int lastN;
        bit sawEmpty;
        logic [9:0] wa;
        flushQueue();
        checkOutput("rd_busy_idle", rd_busy, 0);
        rd_req = 1'b1;
        rd_block_addr = blk;
        @(negedge CLK);
        rd_req = 1'b0;
        rd_block_addr = 8'($urandom);
        checkOutput("rd_busy_set", rd_busy, 1);
        n = 0;
        got = 0;
        lastN = 0;
        sawEmpty = 1'b0;
        while (got < WPB && n < 300) begin
            if (refill_valid) begin
                wa = {blk, 2'(got)};
                checkOutput("refill_idx", refill_idx, got);
                checkOutput("refill_done", refill_done, (got == WPB-1) ? 1 : 0);
                if (modelValid[wa]) checkOutput("refill_data", refill_data, modelMem[wa]);
                if (timed) checkOutput("refill_time", n, MEM_LAT + 1 + got * MEM_LAT);
                else if (got > 0) checkOutput("refill_gap", n - lastN, MEM_LAT);
                if (got == 0 && drainFirst) checkOutput("refill_after_drain", sawEmpty, 1);
                lastN = n;
                got++;
            end else if (wb_empty) begin
                sawEmpty = 1'b1;
            end
            @(negedge CLK);
            n++;
        end
        checkOutput("refill_count", got, WPB);
        checkOutput("refill_pulse", refill_valid, 0);
        checkOutput("rd_busy_clear", rd_busy, 0);
    endtask

    initial begin
        int n;
        int stray;
        bit seen;
        RST = 1'b0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req = 1'b0;
        rd_block_addr = '0;
        repeat (3) @(negedge CLK);
        checkResetValues("por");
        RST = 1'b1;
        @(negedge CLK);

        // Scenario 2: two words of block 0x004, word0 and word3
        $display("[TB] write then timed refill");
        applyStimulus(10'h010, 32'hDEADBEEF);
        applyStimulus(10'h013, 32'h12345678);
        waitEmpty();
        doRead(8'h04, 1'b1, 1'b0);

        // Scenario 3: five back-to-back writes against a 4-entry buffer
        $display("[TB] buffer full stall");
        waitEmpty();
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_ready", wr_ready, 1);
            wr_valid = 1'b1;
            wr_addr  = 10'h100 + 10'(i);
            wr_data  = 32'hC0DE0000 + 32'(i);
            @(negedge CLK);
            wq.push_back('{a: 10'h100 + 10'(i), d: 32'hC0DE0000 + 32'(i)});
        end
        checkOutput("t3_full", wr_ready, 0);
        wr_addr = 10'h104;
        wr_data = 32'hC0DE0004;
        n = 0;
        while (!wr_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("t3_stall_cycles", n, MEM_LAT - 2);
        @(negedge CLK);
        wr_valid = 1'b0;
        wq.push_back('{a: 10'h104, d: 32'hC0DE0004});
        waitEmpty();
        doRead(8'h40, 1'b1, 1'b0);
        doRead(8'h41, 1'b1, 1'b0);

        // Scenario 4: refill requested right behind three queued writes
        $display("[TB] read after write ordering");
        applyStimulus(10'h008, 32'h0BAD0001);
        applyStimulus(10'h009, 32'h0BAD0002);
        applyStimulus(10'h00A, 32'h0BAD0003);
        doRead(8'h02, 1'b0, 1'b1);

        // Scenario 5: two writes to the same word, the later one wins
        $display("[TB] same word overwrite");
        applyStimulus(10'h020, 32'hAAAA0000);
        applyStimulus(10'h020, 32'h5555FFFF);
        doRead(8'h08, 1'b0, 1'b1);

        // Scenario 1: reset with writes in flight and a refill pending
        $display("[TB] reset mid-run");
        applyStimulus(10'h3F0, 32'h11110000);
        applyStimulus(10'h3F4, 32'h22220000);
        waitEmpty();
        applyStimulus(10'h3F0, 32'h11119999);
        applyStimulus(10'h3F4, 32'h22229999);
        rd_req = 1'b1;
        rd_block_addr = 8'hFC;
        @(negedge CLK);
        rd_req = 1'b0;
        #1 RST = 1'b0;
        #1 checkResetValues("mid");
        wq.delete();
        @(negedge CLK);
        RST = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (refill_valid || refill_done || !wb_empty) stray++;
        end
        checkOutput("t1_quiet_after_reset", stray, 0);
        doRead(8'hFC, 1'b1, 1'b0);
        doRead(8'hFD, 1'b1, 1'b0);

        // Scenario 6: reset during a refill after word1
        $display("[TB] reset during refill");
        for (int i = 0; i < WPB; i++) applyStimulus(10'h030 + 10'(i), 32'h60600000 + 32'(i));
        waitEmpty();
        rd_req = 1'b1;
        rd_block_addr = 8'h0C;
        @(negedge CLK);
        rd_req = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            if (refill_valid && refill_idx == 2'd1) seen = 1'b1;
            else begin
                @(negedge CLK);
                n++;
            end
        end
        checkOutput("t6_word1_seen", seen, 1);
        #1 RST = 1'b0;
        #1 checkResetValues("t6");
        @(negedge CLK);
        RST = 1'b1;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (refill_valid || refill_done || rd_busy) stray++;
        end
        checkOutput("t6_no_stray_refill", stray, 0);
        doRead(8'h0C, 1'b1, 1'b0);

        // Randomized mix of writes and refills over blocks 0x80..0x87
        $display("[TB] random mix");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                applyStimulus(10'h200 + 10'($urandom_range(0, 31)), $urandom);
            end else begin
                doRead(8'h80 + 8'($urandom_range(0, 7)), 1'b0, 1'b0);
            end
        end
        waitEmpty();
        for (int b = 0; b < 8; b++) doRead(8'h80 + 8'(b), 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
